vga_sync_decoder: RTL

- Receive-side counterpart of the 640x480 video timer.
- Accepts active-low hsync/vsync and recovers pixel coordinates x/y aligned to the transmitter's counters.
- Verifies line period, hsync pulse width and frame line count, and reports lock status and measurements.
- Sits at the input of a video capture/overlay path, or as a self-checking monitor on the pong video outputs.

---
 rtl/vga_sync_decoder_if.sv | 27 ++
 rtl/vga_sync_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder_if.sv
// Sync-input / recovered-timing bundle for vga_sync_decoder.
// The slave side is the decoder itself; the master side is whatever drives
// the sync lines and consumes the recovered coordinates and status.
interface vga_sync_decoder_if;
   logic        hsync_in;
   logic        vsync_in;
   logic [9:0]  x_out;
   logic [9:0]  y_out;
   logic        locked;
   logic        visible;
   logic        frame_start;
   logic [11:0] line_period;
   logic [10:0] frame_lines;
   logic [7:0]  err_count;

   modport slave (
      input  hsync_in, vsync_in,
      output x_out, y_out, locked, visible, frame_start,
             line_period, frame_lines, err_count
   );

   modport master (
      output hsync_in, vsync_in,
      input  x_out, y_out, locked, visible, frame_start,
             line_period, frame_lines, err_count
   );
endinterface

// File: rtl/vga_sync_decoder.sv
// Receive-side 640x480 timing recovery. Rebuilds the transmitter's x/y
// counters from active-low hsync/vsync, measures line period, hsync width and
// lines per frame, and only declares lock after one fully clean frame.
module vga_sync_decoder #(
   parameter int H_TOTAL      = 800,
   parameter int V_TOTAL      = 521,
   parameter int HS_WIDTH     = 95,
   parameter int H_VISIBLE    = 640,
   parameter int V_VISIBLE    = 480,
   parameter int X_AT_HS_EDGE = 668,
   parameter int Y_AT_VS_EDGE = 490,
   parameter int TIMEOUT      = 1600
) (
   input logic               clk25,
   input logic               rst,
   vga_sync_decoder_if.slave bus
);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [9:0]    X_LAST = 10'(H_TOTAL - 1);
   localparam logic [9:0]    Y_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]    X_LOAD = 10'(X_AT_HS_EDGE);
   localparam logic [9:0]    Y_LOAD = 10'(Y_AT_VS_EDGE);
   localparam logic [9:0]    X_VIS  = 10'(H_VISIBLE);
   localparam logic [9:0]    Y_VIS  = 10'(V_VISIBLE);
   localparam logic [11:0]   P_NOM  = 12'(H_TOTAL);
   localparam logic [11:0]   W_NOM  = 12'(HS_WIDTH);
   localparam logic [10:0]   L_NOM  = 11'(V_TOTAL);
   localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   logic          hs_q, hs_q2, vs_q, vs_q2;
   logic          hfall, vfall, hrise;
   logic [9:0]    x_q, y_q;
   logic [11:0]   pcnt, period_q, wcnt;
   logic [10:0]   lcnt, lines_q;
   logic [TW-1:0] tcnt;
   logic          seen_hfall;
   logic          frame_bad;
   logic          locked_q;
   logic [7:0]    err_q;
   state_t        state;
   logic          period_err, width_err, timeout_err, any_err;

   assign hfall = hs_q2 & ~hs_q;
   assign vfall = vs_q2 & ~vs_q;
   assign hrise = ~hs_q2 & hs_q;

   // The very first fall after reset has no valid predecessor, so its period is not judged.
   assign period_err  = hfall && seen_hfall && (pcnt != P_NOM);
   assign width_err   = hrise && (wcnt != W_NOM);
   // Fires only on the cycle the counter reaches TIMEOUT; it then parks there.
   assign timeout_err = !hfall && (tcnt == T_LAST);
   assign any_err     = period_err | width_err | timeout_err;

   // Two-stage sampling of the sync inputs; idle level is high.
   always_ff @(posedge clk25) begin
      // NOTE: state registers use non-blocking assignments so every flop in
      // this block sees the pre-edge value of the others (hs_q2 gets old hs_q).
      if (rst) begin
         hs_q  <= 1'b1;
         hs_q2 <= 1'b1;
         vs_q  <= 1'b1;
         vs_q2 <= 1'b1;
      end else begin
         hs_q  <= bus.hsync_in;
         hs_q2 <= hs_q;
         vs_q  <= bus.vsync_in;
         vs_q2 <= vs_q;
      end
   end

   // Recovered pixel coordinates, re-phased on every sync fall.
   always_ff @(posedge clk25) begin
      if (rst) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         if (hfall)             x_q <= X_LOAD;
         else if (x_q == X_LAST) x_q <= '0;
         else                   x_q <= x_q + 10'd1;

         if (vfall)                        y_q <= Y_LOAD;
         else if (x_q == X_LAST && !hfall) y_q <= (y_q == Y_LAST) ? '0 : y_q + 10'd1;
      end
   end

   // Timing measurements: line period, hsync width, lines per frame, timeout.
   always_ff @(posedge clk25) begin
      // NOTE: every counter is reset explicitly; the lock decision compares
      // them against exact values, so none may start from an unknown state.
      if (rst) begin
         pcnt       <= '0;
         period_q   <= '0;
         wcnt       <= '0;
         lcnt       <= '0;
         lines_q    <= '0;
         tcnt       <= '0;
         seen_hfall <= 1'b0;
      end else begin
         if (hfall) begin
            pcnt       <= 12'd1;
            period_q   <= pcnt;
            seen_hfall <= 1'b1;
         end else if (pcnt != '1) begin
            pcnt <= pcnt + 12'd1;
         end

         // The fall cycle itself already has hs_q low, so the count restarts at 1.
         if (hfall)                  wcnt <= 12'd1;
         else if (hrise)             wcnt <= '0;
         else if (!hs_q && wcnt != '1) wcnt <= wcnt + 12'd1;

         // A line fall coincident with the frame fall belongs to the new frame.
         if (vfall) begin
            lines_q <= lcnt;
            lcnt    <= hfall ? 11'd1 : 11'd0;
         end else if (hfall && lcnt != '1) begin
            lcnt <= lcnt + 11'd1;
         end

         if (hfall)              tcnt <= '0;
         else if (tcnt != T_MAX) tcnt <= tcnt + 1'b1;
      end
   end

   // Lock FSM: a frame fall opens a verify frame; a clean full frame locks.
   always_ff @(posedge clk25) begin
      if (rst) begin
         state     <= HUNT;
         locked_q  <= 1'b0;
         frame_bad <= 1'b0;
      end else begin
         case (state)
            HUNT: begin
               if (vfall) begin
                  state     <= VERIFY;
                  frame_bad <= 1'b0;
               end
            end
            VERIFY: begin
               if (vfall) begin
                  if (!frame_bad && !any_err && lcnt == L_NOM) begin
                     state    <= LOCKED;
                     locked_q <= 1'b1;
                  end else begin
                     frame_bad <= 1'b0;
                  end
               end else if (any_err) begin
                  frame_bad <= 1'b1;
               end
            end
            LOCKED: begin
               if (any_err || (vfall && lcnt != L_NOM)) begin
                  state    <= HUNT;
                  locked_q <= 1'b0;
               end
            end
            default: begin
               state    <= HUNT;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   // Saturating count of cycles carrying any timing error.
   always_ff @(posedge clk25) begin
      if (rst)                      err_q <= '0;
      else if (any_err && err_q != '1) err_q <= err_q + 8'd1;
   end

   assign bus.x_out       = x_q;
   assign bus.y_out       = y_q;
   assign bus.locked      = locked_q;
   assign bus.line_period = period_q;
   assign bus.frame_lines = lines_q;
   assign bus.err_count   = err_q;
   assign bus.visible     = locked_q && (x_q < X_VIS) && (y_q < Y_VIS);
   assign bus.frame_start = locked_q && (x_q == '0) && (y_q == '0);

endmodule
